// File: rtl/ctrl_pkg.sv
// Shared opcode, control-bundle and exception encodings for the ID-stage
// control decoder, plus the decode result struct and FSM state type.
package ctrl_pkg;

  localparam int BUNDLE_W = 15;

  localparam logic [4:0] OPC_R    = 5'b00000;
  localparam logic [4:0] OPC_01   = 5'b00001;
  localparam logic [4:0] OPC_02   = 5'b00010;
  localparam logic [4:0] OPC_03   = 5'b00011;
  localparam logic [4:0] OPC_04   = 5'b00100;
  localparam logic [4:0] OPC_ADDI = 5'b00101;
  localparam logic [4:0] OPC_06   = 5'b00110;
  localparam logic [4:0] OPC_SW   = 5'b00111;
  localparam logic [4:0] OPC_LW   = 5'b01000;
  localparam logic [4:0] OPC_15   = 5'b10101;
  localparam logic [4:0] OPC_16   = 5'b10110;

  localparam logic [4:0] ALUOP_MUL = 5'b00110;
  localparam logic [4:0] ALUOP_DIV = 5'b00111;

  // {setx,r30,all0,rsmux,pc2,pc1,jal,r31,br,dmwe,aluinb,dmwe_o,rwe,rdst,rwd}
  localparam int B_SETX = 14, B_R30 = 13, B_ALL0 = 12, B_RSMUX = 11, B_PC2 = 10;
  localparam int B_PC1  = 9,  B_JAL = 8,  B_R31  = 7,  B_BR    = 6,  B_DMWE = 5;
  localparam int B_ALUINB = 4, B_DMWE_O = 3, B_RWE = 2, B_RDST = 1, B_RWD = 0;

  localparam logic [BUNDLE_W-1:0] CTL_NOP  = 15'b000000000000000;
  localparam logic [BUNDLE_W-1:0] CTL_R    = 15'b000000000000100;
  localparam logic [BUNDLE_W-1:0] CTL_ADDI = 15'b000000000010110;
  localparam logic [BUNDLE_W-1:0] CTL_LW   = 15'b000000000010111;
  localparam logic [BUNDLE_W-1:0] CTL_SW   = 15'b000000000111001;
  localparam logic [BUNDLE_W-1:0] CTL_01   = 15'b000001000000100;
  localparam logic [BUNDLE_W-1:0] CTL_02   = 15'b000000001001100;
  localparam logic [BUNDLE_W-1:0] CTL_03   = 15'b000001110000100;
  localparam logic [BUNDLE_W-1:0] CTL_04   = 15'b000010000001100;
  localparam logic [BUNDLE_W-1:0] CTL_06   = 15'b000100001001100;
  localparam logic [BUNDLE_W-1:0] CTL_16   = 15'b001100001000100;
  localparam logic [BUNDLE_W-1:0] CTL_15   = 15'b110000000000100;

  localparam logic [1:0] EXC_NONE = 2'd0;
  localparam logic [1:0] EXC_MUL  = 2'd1;
  localparam logic [1:0] EXC_DIV  = 2'd2;
  localparam logic [1:0] EXC_TMO  = 2'd3;

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  typedef struct packed {
    logic [BUNDLE_W-1:0] ctrl;
    logic                addi;
    logic                sw;
    logic                lw;
    logic                is_md;
    logic                is_div;
  } dec_t;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational opcode/aluop decode into control bundle, side signals
// and mul/div classification.
module ctrl_decode_comb import ctrl_pkg::*; #(
  parameter int OP_W       = 5,
  parameter int ALUOP_W    = 5,
  parameter int SUPPORT_MD = 1
) (
  input  logic [OP_W-1:0]    opcode,
  input  logic [ALUOP_W-1:0] aluop,
  output dec_t               dec
);

  always_comb begin
    dec = '0;
    case (opcode)
      OP_W'(OPC_R):    dec.ctrl = CTL_R;
      OP_W'(OPC_01):   dec.ctrl = CTL_01;
      OP_W'(OPC_02):   dec.ctrl = CTL_02;
      OP_W'(OPC_03):   dec.ctrl = CTL_03;
      OP_W'(OPC_04):   dec.ctrl = CTL_04;
      OP_W'(OPC_ADDI): dec.ctrl = CTL_ADDI;
      OP_W'(OPC_06):   dec.ctrl = CTL_06;
      OP_W'(OPC_SW):   dec.ctrl = CTL_SW;
      OP_W'(OPC_LW):   dec.ctrl = CTL_LW;
      OP_W'(OPC_15):   dec.ctrl = CTL_15;
      OP_W'(OPC_16):   dec.ctrl = CTL_16;
      default:         dec.ctrl = CTL_NOP;
    endcase
    dec.addi = (opcode == OP_W'(OPC_ADDI));
    dec.sw   = (opcode == OP_W'(OPC_SW));
    dec.lw   = (opcode == OP_W'(OPC_LW));
    // With sequencing disabled, mul/div fall through as ordinary R-type.
    dec.is_md  = (SUPPORT_MD != 0) && (opcode == OP_W'(OPC_R)) &&
                 ((aluop == ALUOP_W'(ALUOP_MUL)) || (aluop == ALUOP_W'(ALUOP_DIV)));
    dec.is_div = dec.is_md && (aluop == ALUOP_W'(ALUOP_DIV));
  end

endmodule

// File: rtl/ctrl_pipe_decoder.sv
// Registered, handshaked ID-stage control decoder with mul/div sequencing
// (start/ready/exception) and a WAIT-state timeout.
module ctrl_pipe_decoder import ctrl_pkg::*; #(
  parameter int OP_W       = 5,
  parameter int ALUOP_W    = 5,
  parameter int CTRL_W     = 15,
  parameter int MD_TIMEOUT = 40,
  parameter int SUPPORT_MD = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    opcode,
  input  logic [ALUOP_W-1:0] aluop,
  input  logic               flush,
  input  logic               ex_ready,
  output logic               out_valid,
  output logic [CTRL_W-1:0]  ctrl_out,
  output logic               addi_out,
  output logic               sw_out,
  output logic               lw_out,
  output logic               md_start,
  output logic               md_is_div,
  output logic               md_busy,
  input  logic               md_ready,
  input  logic               md_exception,
  output logic               exc_valid,
  output logic [1:0]         exc_code
);

  localparam int CNT_W = $clog2(MD_TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  dec_t               dec;
  logic               accept;
  logic               ov_d, addi_d, sw_d, lw_d, start_d, isdiv_d, excv_d;
  logic [CTRL_W-1:0]  ctrl_d;
  logic [1:0]         excc_d;

  ctrl_decode_comb #(.OP_W(OP_W), .ALUOP_W(ALUOP_W), .SUPPORT_MD(SUPPORT_MD)) u_dec (
    .opcode (opcode),
    .aluop  (aluop),
    .dec    (dec)
  );

  // Qualified by reset so every output reads 0 while reset is held.
  assign in_ready = reset_n & (state_q == ST_IDLE) & (~out_valid | ex_ready);
  assign accept   = in_valid & in_ready & ~flush;
  assign md_busy  = (state_q == ST_WAIT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ov_d    = out_valid;
    ctrl_d  = ctrl_out;
    addi_d  = addi_out;
    sw_d    = sw_out;
    lw_d    = lw_out;
    start_d = 1'b0;
    isdiv_d = md_is_div;
    excv_d  = 1'b0;
    excc_d  = EXC_NONE;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ov_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && dec.is_md) begin
            ov_d    = 1'b0;
            start_d = 1'b1;
            isdiv_d = dec.is_div;
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else if (accept) begin
            ov_d   = 1'b1;
            ctrl_d = CTRL_W'(dec.ctrl);
            addi_d = dec.addi;
            sw_d   = dec.sw;
            lw_d   = dec.lw;
          end else if (ex_ready) begin
            ov_d = 1'b0;
          end
        end
        ST_WAIT: begin
          // Ready wins over a timeout landing in the same cycle.
          if (md_ready) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            ov_d    = 1'b1;
            ctrl_d  = CTRL_W'(CTL_R);
            addi_d  = 1'b0;
            sw_d    = 1'b0;
            lw_d    = 1'b0;
            if (md_exception) begin
              excv_d = 1'b1;
              excc_d = md_is_div ? EXC_DIV : EXC_MUL;
            end
          end else if (cnt_q == CNT_W'(MD_TIMEOUT - 1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            excv_d  = 1'b1;
            excc_d  = EXC_TMO;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      ctrl_out  <= '0;
      addi_out  <= 1'b0;
      sw_out    <= 1'b0;
      lw_out    <= 1'b0;
      md_start  <= 1'b0;
      md_is_div <= 1'b0;
      exc_valid <= 1'b0;
      exc_code  <= EXC_NONE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_valid <= ov_d;
      ctrl_out  <= ctrl_d;
      addi_out  <= addi_d;
      sw_out    <= sw_d;
      lw_out    <= lw_d;
      md_start  <= start_d;
      md_is_div <= isdiv_d;
      exc_valid <= excv_d;
      exc_code  <= excc_d;
    end
  end

endmodule

// File: tb/tb_ctrl_pipe_decoder.sv
// Bench for ctrl_pipe_decoder: directed scenarios plus random traffic checked
// against a transaction-level reference built from the decode table and rules.
module tb_ctrl_pipe_decoder;

  localparam int TMO = 40;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, flush, ex_ready;
  logic [4:0]  opcode, aluop;
  logic        out_valid;
  logic [14:0] ctrl_out;
  logic        addi_out, sw_out, lw_out;
  logic        md_start, md_is_div, md_busy, md_ready, md_exception;
  logic        exc_valid;
  logic [1:0]  exc_code;

  int n_tests = 0;
  int n_fail  = 0;

  // reference state
  logic [14:0] tab [32];
  bit          m_ov, m_busy, m_start, m_div, m_exc;
  int          m_code, m_waited, lat;
  logic [14:0] m_ctrl;
  logic [2:0]  m_side;

  always #5 clock = ~clock;

  ctrl_pipe_decoder #(
    .OP_W(5), .ALUOP_W(5), .CTRL_W(15), .MD_TIMEOUT(TMO), .SUPPORT_MD(1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .aluop(aluop), .flush(flush), .ex_ready(ex_ready),
    .out_valid(out_valid), .ctrl_out(ctrl_out), .addi_out(addi_out),
    .sw_out(sw_out), .lw_out(lw_out), .md_start(md_start), .md_is_div(md_is_div),
    .md_busy(md_busy), .md_ready(md_ready), .md_exception(md_exception),
    .exc_valid(exc_valid), .exc_code(exc_code)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ov = 0; m_busy = 0; m_start = 0; m_div = 0; m_exc = 0;
    m_code = 0; m_waited = 0; m_ctrl = '0; m_side = '0;
  endtask

  task automatic chk_zero();
    chk("rst in_ready",  32'(in_ready), 0);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst ctrl_out",  32'(ctrl_out), 0);
    chk("rst sides",     32'({addi_out, sw_out, lw_out}), 0);
    chk("rst md",        32'({md_start, md_is_div, md_busy}), 0);
    chk("rst exc",       32'({exc_valid, exc_code}), 0);
  endtask

  task automatic chk_outs();
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      chk("ctrl_out", 32'(ctrl_out), 32'(m_ctrl));
      chk("sides",    32'({addi_out, sw_out, lw_out}), 32'(m_side));
    end
    chk("md_start", 32'(md_start), 32'(m_start));
    if (m_start) chk("md_is_div", 32'(md_is_div), 32'(m_div));
    chk("md_busy",   32'(md_busy), 32'(m_busy));
    chk("exc_valid", 32'(exc_valid), 32'(m_exc));
    if (m_exc) chk("exc_code", 32'(exc_code), m_code);
  endtask

  // Entered just after a falling edge; returns at the next falling edge.
  task automatic step(input int iv, input int op, input int al, input int fl,
                      input int exr, input int mdr, input int mde);
    bit rdy, acc;
    chk_outs();
    in_valid = 1'(iv); opcode = 5'(op); aluop = 5'(al); flush = 1'(fl);
    ex_ready = 1'(exr); md_ready = 1'(mdr); md_exception = 1'(mde);
    #1;
    rdy = !m_busy && (!m_ov || exr != 0);
    chk("in_ready", 32'(in_ready), 32'(rdy));
    acc = (iv != 0) && rdy && (fl == 0);
    m_start = 0; m_exc = 0; m_code = 0;
    if (fl != 0) begin
      m_ov = 0; m_busy = 0; m_waited = 0;
    end else if (m_busy) begin
      if (mdr != 0) begin
        m_busy = 0; m_ov = 1; m_ctrl = tab[0]; m_side = 3'b000;
        if (mde != 0) begin m_exc = 1; m_code = m_div ? 2 : 1; end
      end else if (m_waited == TMO) begin
        m_busy = 0; m_exc = 1; m_code = 3;
      end else begin
        m_waited++;
      end
    end else if (acc) begin
      if (op == 0 && (al == 6 || al == 7)) begin
        m_busy = 1; m_waited = 1; m_start = 1; m_div = (al == 7); m_ov = 0;
        lat = int'($urandom_range(1, 45));
      end else begin
        m_ov = 1; m_ctrl = tab[op[4:0]];
        m_side = {op == 5, op == 7, op == 8};
      end
    end else if (exr != 0) begin
      m_ov = 0;
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    int op, al, mdr;
    for (int i = 0; i < 32; i++) tab[i] = '0;
    tab[0]  = 15'b000000000000100; tab[5]  = 15'b000000000010110;
    tab[8]  = 15'b000000000010111; tab[7]  = 15'b000000000111001;
    tab[1]  = 15'b000001000000100; tab[2]  = 15'b000000001001100;
    tab[3]  = 15'b000001110000100; tab[4]  = 15'b000010000001100;
    tab[6]  = 15'b000100001001100; tab[22] = 15'b001100001000100;
    tab[21] = 15'b110000000000100;
    in_valid = 0; opcode = 0; aluop = 0; flush = 0; ex_ready = 0;
    md_ready = 0; md_exception = 0; lat = 0;
    reset_n = 0;
    model_reset();
    repeat (2) @(negedge clock);
    chk_zero();
    reset_n = 1;

    // addi, then lw held by back-pressure while sw waits
    step(1, 5, 0, 0, 1, 0, 0); idle(1);
    step(1, 8, 0, 0, 1, 0, 0);
    repeat (3) step(1, 7, 0, 0, 0, 0, 0);
    step(1, 7, 0, 0, 1, 0, 0); idle(1);
    // mul, ready on fifth WAIT cycle
    step(1, 0, 6, 0, 1, 0, 0); idle(4); step(0, 0, 0, 0, 1, 1, 0); idle(2);
    // div with exception
    step(1, 0, 7, 0, 1, 0, 0); idle(1); step(0, 0, 0, 0, 1, 1, 1); idle(2);
    // div timeout
    step(1, 0, 7, 0, 1, 0, 0); idle(TMO + 2);
    // flush in WAIT beats same-cycle md_ready
    step(1, 0, 6, 0, 1, 0, 0); idle(2); step(0, 0, 0, 1, 1, 1, 1); idle(2);
    // unknown opcode decodes to nop but still valid
    step(1, 31, 0, 0, 1, 0, 0); idle(1);
    // async reset right after md_start
    step(1, 0, 7, 0, 1, 0, 0);
    #2 reset_n = 0;
    #1 chk_zero();
    @(negedge clock);
    reset_n = 1;
    model_reset();
    idle(3);

    repeat (3000) begin
      op = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 31));
      al = (op == 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(6, 7))
                                                  : int'($urandom_range(0, 31));
      mdr = m_busy ? int'(m_waited == lat) : int'($urandom_range(0, 7) == 0);
      step(int'($urandom_range(0, 3) != 0), op, al, int'($urandom_range(0, 15) == 0),
           int'($urandom_range(0, 3) != 0), mdr, int'($urandom_range(0, 2) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
